// File: rtl/control_idle_diferencial.sv
// control_idle_diferencial
// Sequences the differential transmitter in and out of electrical idle
// (IDLE -> WAKE -> ACTIVE -> DRAIN -> IDLE), grants bit slots to the
// serializer and debounces the receiver transition pulse into RxElecIdle.
module control_idle_diferencial #(
    parameter int WAKE_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       txReq,
    input  logic       txUltimo,
    input  logic       rxTransicion,
    output logic       TxElecIdle,
    output logic       txEnb,
    output logic       listo,
    output logic       RxElecIdle,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAKE   = 2'b01,
        ACTIVE = 2'b10,
        DRAIN  = 2'b11
    } estado_t;

    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_SAT     = CNT_W'(IDLE_TIMEOUT);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_idle_q, rx_idle_d;
    logic             tx_elec_idle_q, tx_elec_idle_d;
    logic             tx_enb_q, tx_enb_d;

    // Transmit sequencing: next state and shared WAKE/DRAIN counter.
    // The counter is cleared on every state entry; enb low forces IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enb) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (txReq) begin
                        state_d = WAKE;
                        cnt_d   = '0;
                    end
                end
                WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    // A burst ends on its last bit or on any gap in txReq.
                    if (!txReq || txUltimo) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Driver controls are registered decodes of the next state.
        tx_elec_idle_d = (state_d == IDLE);
        tx_enb_d       = (state_d != IDLE);
    end

    // Receive idle detector: a transition always beats saturation.
    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rxTransicion) begin
            rx_cnt_d = '0;
        end else if (rx_cnt_q != RX_SAT) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
        rx_idle_d = !rxTransicion && (rx_cnt_d == RX_SAT);
    end

    // State and output registers; reset parks the line in idle on both sides.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_cnt_q       <= RX_SAT;
            rx_idle_q      <= 1'b1;
            tx_elec_idle_q <= 1'b1;
            tx_enb_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_idle_q      <= rx_idle_d;
            tx_elec_idle_q <= tx_elec_idle_d;
            tx_enb_q       <= tx_enb_d;
        end
    end

    // Slot grant drops in the same cycle enb goes low.
    assign listo      = (state_q == ACTIVE) && enb;
    assign TxElecIdle = tx_elec_idle_q;
    assign txEnb      = tx_enb_q;
    assign RxElecIdle = rx_idle_q;
    assign estado     = state_q;

endmodule

// File: tb/tb_control_idle_diferencial.sv
// Bench for control_idle_diferencial: default-parameter instance and a
// 1/1/1 instance driven by the same stimulus, each against its own
// phase/countdown reference model.
module tb_control_idle_diferencial;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enb = 1'b0;
    logic txReq = 1'b0;
    logic txUltimo = 1'b0;
    logic rxTransicion = 1'b0;

    logic       a_tei, a_txe, a_lis, a_rei;
    logic [1:0] a_est;
    logic       b_tei, b_txe, b_lis, b_rei;
    logic [1:0] b_est;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_idle_diferencial #(
        .WAKE_CYCLES(4), .DRAIN_CYCLES(2), .IDLE_TIMEOUT(16), .CNT_W(5)
    ) dut_a (
        .clk(clk), .rst(rst), .enb(enb), .txReq(txReq), .txUltimo(txUltimo),
        .rxTransicion(rxTransicion), .TxElecIdle(a_tei), .txEnb(a_txe),
        .listo(a_lis), .RxElecIdle(a_rei), .estado(a_est)
    );

    control_idle_diferencial #(
        .WAKE_CYCLES(1), .DRAIN_CYCLES(1), .IDLE_TIMEOUT(1), .CNT_W(5)
    ) dut_b (
        .clk(clk), .rst(rst), .enb(enb), .txReq(txReq), .txUltimo(txUltimo),
        .rxTransicion(rxTransicion), .TxElecIdle(b_tei), .txEnb(b_txe),
        .listo(b_lis), .RxElecIdle(b_rei), .estado(b_est)
    );

    // Reference model: phase 0 idle, 1 waking, 2 active, 3 draining.
    // 'left' counts down the edges still to spend in wake/drain;
    // 'quiet' counts edges since the last receive transition.
    localparam int BIG = 100000;
    int p_wake [2] = '{4, 1};
    int p_drain[2] = '{2, 1};
    int p_to   [2] = '{16, 1};
    int ph     [2];
    int left   [2];
    int quiet  [2];

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = 0; left[k] = 0; quiet[k] = BIG;
            end else begin
                quiet[k] = rxTransicion ? 0 : ((quiet[k] >= BIG) ? BIG : quiet[k] + 1);
                if (!enb) begin
                    ph[k] = 0;
                end else if (ph[k] == 0) begin
                    if (txReq) begin ph[k] = 1; left[k] = p_wake[k]; end
                end else if (ph[k] == 1 || ph[k] == 3) begin
                    left[k] = left[k] - 1;
                    if (left[k] == 0) ph[k] = (ph[k] == 1) ? 2 : 0;
                end else begin
                    if (!txReq || txUltimo) begin ph[k] = 3; left[k] = p_drain[k]; end
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] est_e;
            est_e = 2'(ph[k]);
            cmp("TxElecIdle", k, {1'b0, (k == 0) ? a_tei : b_tei}, {1'b0, ph[k] == 0});
            cmp("txEnb",      k, {1'b0, (k == 0) ? a_txe : b_txe}, {1'b0, ph[k] != 0});
            cmp("listo",      k, {1'b0, (k == 0) ? a_lis : b_lis}, {1'b0, (ph[k] == 2) && enb});
            cmp("RxElecIdle", k, {1'b0, (k == 0) ? a_rei : b_rei}, {1'b0, quiet[k] >= p_to[k]});
            cmp("estado",     k, (k == 0) ? a_est : b_est, est_e);
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then take the edge.
    task automatic cyc(input logic r, input logic e, input logic q, input logic u,
                       input logic x, input bit chk = 1'b1);
        rst = r; enb = e; txReq = q; txUltimo = u; rxTransicion = x;
        #2;
        if (chk) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset with txReq and rxTransicion held high.
        cyc(1, 1, 1, 0, 1, 1'b0);
        cyc(1, 1, 1, 0, 1);
        // Quiet idle cycles, enb high, no request.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, i == 0);
        // 3-bit burst: 4 wake edges, then bits with txUltimo on the third, then drain.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        // Burst gap: one-cycle txReq drop in ACTIVE, re-request during DRAIN.
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, i % 10 == 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, i % 10 == 5);
        // enb low mid-ACTIVE with a pending bit.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        // Receive pulses every 10 cycles, then silence, then single pulses.
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, i % 10 == 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0, 0);
        // Reset mid-burst: listo drops after the reset edge with no drain.
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, e, q, u, x;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 19) != 0);
            q = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 5) == 0);
            x = (i < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 29) == 0);
            cyc(r, e, q, u, x);
        end
        cyc(0, 1, 0, 0, 0);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
